// File: rtl/archer_dmem_responder.sv
// Data-memory responder for archer_rv32if: one request at a time, programmable wait states.
// Optional build macro ARCHER_DMEM_RANGE_ERR_EN flags accesses beyond DEPTH words with rsp_err.
module archer_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_oor;
  logic          req_oor;
  logic          access;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH];

`ifdef ARCHER_DMEM_RANGE_ERR_EN
  // DEPTH is a power of two, so any set bit above the index field means word >= DEPTH.
  assign req_oor = |req_addr[31:AW+2];
`else
  assign req_oor = 1'b0;
`endif

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  // The access edge is the one on which WAIT sees an expired counter.
  assign access = (state == S_WAIT) && (cnt == 4'd0);

  // NOTE: the RAM array is deliberately left out of reset; only control state is reset,
  // which keeps it mappable onto block RAM and lets completed stores survive a reset.
  always_ff @(posedge clk) begin
    if (access && lat_we && !lat_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      lat_oor   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_idx   <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_oor   <= req_oor;
            cnt       <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= lat_oor;
            rsp_rdata <= (lat_we || lat_oor) ? 32'd0 : mem[lat_idx];
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
